mod1000_add_sched: RTL

- Shares one 10-bit ripple-carry adder (add10 / FA chain) between two requesters and sequences a modulo-MOD addition on it.
- Each transaction takes two adder passes. Pass 1 forms a+b. Pass 2 does a conditional correction by adding 2^W−MOD.
- Sits between the mod-1000 counter/accumulator clients and the shared adder datapath.
- Uses valid/ready handshakes on both the request side and the response side.

---
 rtl/mod1000_add_sched.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mod1000_add_sched.sv
// Modulo-MOD adder scheduler: two valid/ready requesters share one W-bit
// ripple-carry adder. Each operation runs two adder passes: a+b, then a
// conditional correction by adding K = 2^W - MOD.

// W-bit ripple-carry adder built from a full-adder chain; o_sum[W] is carry-out.
module mod1000_add_sched_fa_chain #(
  parameter int W = 10
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W:0]   o_sum
);
  logic [W:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
  end

  assign o_sum[W] = w_c[W];
endmodule

module mod1000_add_sched #(
  parameter int W   = 10,
  parameter int MOD = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_err,
  output logic         busy
);
  // Correction constant: adding 2^W - MOD modulo 2^W subtracts MOD.
  localparam logic [W-1:0] K     = W'((1 << W) - MOD);
  localparam logic [W:0]   MOD_C = (W+1)'(MOD);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_RED, S_RESP} state_t;

  state_t       r_state, w_next;
  logic         r_last_id, r_id, r_err;
  logic [W-1:0] r_a, r_b, r_res;
  logic [W:0]   r_s;

  logic         w_gnt0, w_gnt1, w_idle, w_acc, w_gid;
  logic [W-1:0] w_opa, w_opb;
  logic [W:0]   w_sum;

  // Round-robin only matters under contention: a lone requester always wins.
  assign w_gnt0     = req0_valid & (~req1_valid | r_last_id);
  assign w_gnt1     = req1_valid & (~req0_valid | ~r_last_id);
  assign w_idle     = (r_state == S_IDLE) & ~rst;
  assign req0_ready = w_idle & w_gnt0;
  assign req1_ready = w_idle & w_gnt1;
  assign w_acc      = req0_ready | req1_ready;
  assign w_gid      = req1_ready;

  // Operand steering for the single shared adder.
  always_comb begin
    w_opa = '0;
    w_opb = '0;
    case (r_state)
      S_ADD: begin
        w_opa = r_a;
        w_opb = r_b;
      end
      S_RED: begin
        w_opa = r_s[W-1:0];
        w_opb = K;
      end
      default: ;
    endcase
  end

  mod1000_add_sched_fa_chain #(.W(W)) u_add (
    .i_a   (w_opa),
    .i_b   (w_opb),
    .i_cin (1'b0),
    .o_sum (w_sum)
  );

  // Next-state: fixed IDLE -> ADD -> RED -> RESP walk, RESP waits on the consumer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_acc) w_next = S_ADD;
      S_ADD:   w_next = S_RED;
      S_RED:   w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Datapath: capture request, first-pass sum, then corrected result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_id <= 1'b1;
      r_id      <= 1'b0;
      r_err     <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_s       <= '0;
      r_res     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_acc) begin
          r_a       <= w_gid ? req1_a : req0_a;
          r_b       <= w_gid ? req1_b : req0_b;
          r_id      <= w_gid;
          r_last_id <= w_gid;
        end
        S_ADD: begin
          r_s   <= w_sum;
          r_err <= ({1'b0, r_a} >= MOD_C) | ({1'b0, r_b} >= MOD_C);
        end
        S_RED: r_res <= (r_s >= MOD_C) ? w_sum[W-1:0] : r_s[W-1:0];
        default: ;
      endcase
    end
  end

  // Outputs are forced to zero while reset is asserted.
  assign rsp_valid = (r_state == S_RESP) & ~rst;
  assign rsp_sum   = rst ? '0 : r_res;
  assign rsp_id    = r_id & ~rst;
  assign rsp_err   = r_err & ~rst;
  assign busy      = (r_state != S_IDLE) & ~rst;
endmodule
